// File: rtl/c_drain.sv
// c_drain: result-drain stage behind the TPU core. After a matmul it reads
// the packed C-buffer words (one per (row, column block)) and streams the
// M x N result one element per beat, row-major, over valid/ready.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, M, N        one-cycle start pulse with result rows/columns
//   busy, done         drain in progress / one-cycle completion pulse
//   c_rd_en            C-buffer read strobe (only in the fetch cycle)
//   c_rd_index         C-buffer word address, nb*M + m
//   c_rd_data          C-buffer read data, 1-cycle latency, lane 0 in MSBs
//   out_valid/ready    element stream handshake
//   out_data, out_last element value, high on C[M-1][N-1]
module c_drain #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              M,
    input  logic [7:0]              N,
    output logic                    busy,
    output logic                    done,
    output logic                    c_rd_en,
    output logic [IDX_W-1:0]        c_rd_index,
    input  logic [LANES*DATA_W-1:0] c_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned WORD_W = LANES * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT} state_t;

    state_t              state_q, state_d;
    logic [7:0]          m_r_q, m_r_d;
    logic [7:0]          n_r_q, n_r_d;
    logic [7:0]          m_cnt_q, m_cnt_d;
    logic [5:0]          nb_cnt_q, nb_cnt_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_en_q, rd_en_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;

    logic [15:0]         col_base;
    logic [15:0]         col_cur;
    logic [15:0]         n_last;
    logic                row_last;
    logic [LANE_W-1:0]   lane_nxt;

    // Lane k of a word sits at the k-th DATA_W slice counted from the MSB.
    function automatic logic [DATA_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                   input logic [LANE_W-1:0] k);
        logic [WORD_W-1:0] sh;
        sh = w << (DATA_W * k);
        return sh[WORD_W-1 -: DATA_W];
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [15:0] nb,
                                                    input logic [7:0]  rows,
                                                    input logic [7:0]  m);
        logic [15:0] idx;
        idx = nb * 16'(rows) + 16'(m);
        return IDX_W'(idx);
    endfunction

    always_comb begin
        col_base = 16'(nb_cnt_q) * 16'(LANES);
        col_cur  = col_base + 16'(lane_q);
        n_last   = 16'(n_r_q) - 16'd1;
        row_last = (m_cnt_q == m_r_q - 8'd1);
        lane_nxt = lane_q + LANE_W'(1);

        state_d  = state_q;
        m_r_d    = m_r_q;
        n_r_d    = n_r_q;
        m_cnt_d  = m_cnt_q;
        nb_cnt_d = nb_cnt_q;
        lane_d   = lane_q;
        word_d   = word_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_en_d  = 1'b0;
        rd_idx_d = rd_idx_q;
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (M != 8'd0 && N != 8'd0) begin
                        m_r_d    = M;
                        n_r_d    = N;
                        m_cnt_d  = '0;
                        nb_cnt_d = '0;
                        lane_d   = '0;
                        busy_d   = 1'b1;
                        rd_en_d  = 1'b1;
                        rd_idx_d = '0;
                        state_d  = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                word_d  = c_rd_data;
                lane_d  = '0;
                valid_d = 1'b1;
                data_d  = lane_sel(c_rd_data, '0);
                last_d  = row_last && (col_base == n_last);
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (lane_q != LANE_W'(LANES - 1) && (col_cur + 16'd1) < 16'(n_r_q)) begin
                        lane_d = lane_nxt;
                        data_d = lane_sel(word_q, lane_nxt);
                        last_d = row_last && ((col_cur + 16'd1) == n_last);
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if ((col_base + 16'(LANES)) < 16'(n_r_q)) begin
                            nb_cnt_d = nb_cnt_q + 6'd1;
                            rd_en_d  = 1'b1;
                            rd_idx_d = word_index(16'(nb_cnt_q) + 16'd1, m_r_q, m_cnt_q);
                            state_d  = S_FETCH;
                        end else begin
                            nb_cnt_d = '0;
                            if (row_last) begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                m_cnt_d  = m_cnt_q + 8'd1;
                                rd_en_d  = 1'b1;
                                rd_idx_d = word_index(16'd0, m_r_q, m_cnt_q + 8'd1);
                                state_d  = S_FETCH;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            m_r_q    <= '0;
            n_r_q    <= '0;
            m_cnt_q  <= '0;
            nb_cnt_q <= '0;
            lane_q   <= '0;
            word_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_idx_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_r_q    <= m_r_d;
            n_r_q    <= n_r_d;
            m_cnt_q  <= m_cnt_d;
            nb_cnt_q <= nb_cnt_d;
            lane_q   <= lane_d;
            word_q   <= word_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            rd_idx_q <= rd_idx_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign c_rd_en    = rd_en_q;
    assign c_rd_index = rd_idx_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_last   = last_q;

endmodule

// File: tb/tb_c_drain.sv
// tb_c_drain: directed bench for c_drain with a C-buffer memory model
// (1-cycle synchronous read) and a sink that records every accepted beat
// and every read index.
module tb_c_drain;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   M = '0;
    logic [7:0]   N = '0;
    logic         busy, done, c_rd_en, out_valid, out_last;
    logic [15:0]  c_rd_index;
    logic [127:0] c_rd_data = '0;
    logic         out_ready;
    logic [31:0]  out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] mem [64];

    logic [31:0]  beat_data_q [$];
    bit           beat_last_q [$];
    int unsigned  rd_idx_q [$];
    int           done_cnt = 0;
    int           busy_cnt = 0;

    int           ready_mode = 0;
    bit [3:0]     ready_pat = 4'b1001;
    int           ready_k = 0;

    bit           prev_stall = 1'b0;
    logic [31:0]  prev_data = '0;
    logic         prev_last = 1'b0;

    c_drain #(.LANES(4), .DATA_W(32), .IDX_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .M          (M),
        .N          (N),
        .busy       (busy),
        .done       (done),
        .c_rd_en    (c_rd_en),
        .c_rd_index (c_rd_index),
        .c_rd_data  (c_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (c_rd_en) c_rd_data <= mem[c_rd_index[5:0]];
    end

    // Sink ready: constant 1, or the repeating 1,0,0,1 pattern.
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            out_ready = ready_pat[3 - ready_k];
            ready_k   = (ready_k + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(out_valid), 64'd1);
                check_eq("stall_data", 64'(out_data), 64'(prev_data));
                check_eq("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                beat_data_q.push_back(out_data);
                beat_last_q.push_back(out_last);
            end
            if (c_rd_en) rd_idx_q.push_back(int'(c_rd_index));
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    function automatic logic [31:0] cval(input logic [31:0] base, input int m, input int n);
        return base + 32'(m * 16 + n);
    endfunction

    task automatic fill_mem(input int m, input int n, input logic [31:0] base);
        int nbk;
        logic [127:0] w;
        nbk = (n + 3) / 4;
        for (int nb = 0; nb < nbk; nb++) begin
            for (int mm = 0; mm < m; mm++) begin
                w = '0;
                for (int k = 0; k < 4; k++) begin
                    if (nb * 4 + k < n) w[127 - 32 * k -: 32] = cval(base, mm, nb * 4 + k);
                    else                w[127 - 32 * k -: 32] = 32'hBAD0_0000 | 32'(k);
                end
                mem[nb * m + mm] = w;
            end
        end
    endtask

    task automatic do_start(input int m, input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        M     = 8'(m);
        N     = 8'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles after the start edge until done is seen.
    task automatic wait_done(input int budget, output int cyc, output bit found);
        cyc   = 0;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (done) found = 1'b1;
        end
        #1;
    endtask

    task automatic check_stream(input string tag, input int m, input int n,
                                input logic [31:0] base, input int b0, input int r0);
        int nbk;
        int i;
        nbk = (n + 3) / 4;
        check_eq({tag, "_beats"}, 64'(beat_data_q.size() - b0), 64'(m * n));
        if (beat_data_q.size() - b0 == m * n) begin
            for (int mm = 0; mm < m; mm++) begin
                for (int nn = 0; nn < n; nn++) begin
                    i = b0 + mm * n + nn;
                    check_eq({tag, "_data"}, 64'(beat_data_q[i]), 64'(cval(base, mm, nn)));
                    check_eq({tag, "_last"}, 64'(beat_last_q[i]),
                             64'((mm == m - 1) && (nn == n - 1)));
                end
            end
        end
        check_eq({tag, "_reads"}, 64'(rd_idx_q.size() - r0), 64'(m * nbk));
        if (rd_idx_q.size() - r0 == m * nbk) begin
            i = r0;
            for (int mm = 0; mm < m; mm++) begin
                for (int nb = 0; nb < nbk; nb++) begin
                    check_eq({tag, "_idx"}, 64'(rd_idx_q[i]), 64'(nb * m + mm));
                    i++;
                end
            end
        end
    endtask

    task automatic run_drain(input string tag, input int m, input int n,
                             input logic [31:0] base, input int rmode, input int exp_cyc);
        int b0, r0, d0, cyc;
        bit found;
        fill_mem(m, n, base);
        ready_mode = rmode;
        b0 = beat_data_q.size();
        r0 = rd_idx_q.size();
        d0 = done_cnt;
        do_start(m, n);
        wait_done(2000, cyc, found);
        check_eq({tag, "_done_seen"}, 64'(found), 64'd1);
        if (exp_cyc > 0) check_eq({tag, "_done_cyc"}, 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        #1;
        ready_mode = 0;
        check_stream(tag, m, n, base, b0, r0);
        check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_rd_en"}, 64'(c_rd_en), 64'd0);
        check_eq({tag, "_rd_index"}, 64'(c_rd_index), 64'd0);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_data"}, 64'(out_data), 64'd0);
        check_eq({tag, "_last"}, 64'(out_last), 64'd0);
    endtask

    initial begin
        int b0, r0, d0, bc0, cyc, lasts;
        bit found;

        for (int i = 0; i < 64; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word: lanes A,B,C of {A,B,C,D}, done 6 cycles after start.
        mem[0] = {32'hA, 32'hB, 32'hC, 32'hD};
        b0 = beat_data_q.size();
        r0 = rd_idx_q.size();
        do_start(1, 3);
        wait_done(100, cyc, found);
        check_eq("single_done_seen", 64'(found), 64'd1);
        check_eq("single_done_cyc", 64'(cyc), 64'd6);
        @(negedge clk);
        #1;
        check_eq("single_beats", 64'(beat_data_q.size() - b0), 64'd3);
        if (beat_data_q.size() - b0 == 3) begin
            check_eq("single_b0", 64'(beat_data_q[b0]), 64'hA);
            check_eq("single_b1", 64'(beat_data_q[b0 + 1]), 64'hB);
            check_eq("single_b2", 64'(beat_data_q[b0 + 2]), 64'hC);
            check_eq("single_last0", 64'(beat_last_q[b0]), 64'd0);
            check_eq("single_last1", 64'(beat_last_q[b0 + 1]), 64'd0);
            check_eq("single_last2", 64'(beat_last_q[b0 + 2]), 64'd1);
        end
        check_eq("single_reads", 64'(rd_idx_q.size() - r0), 64'd1);
        if (rd_idx_q.size() - r0 == 1) check_eq("single_idx", 64'(rd_idx_q[r0]), 64'd0);

        // Full tile M=4, N=8: value m*16+n, last only on 55.
        b0 = beat_data_q.size();
        run_drain("tile", 4, 8, 32'h0, 0, 49);
        lasts = 0;
        for (int i = b0; i < beat_data_q.size(); i++) if (beat_last_q[i]) lasts++;
        check_eq("tile_last_count", 64'(lasts), 64'd1);
        check_eq("tile_final_value", 64'(beat_data_q[beat_data_q.size() - 1]), 64'd55);

        // Back-pressure M=2, N=5: index order 0,2,1,3.
        r0 = rd_idx_q.size();
        run_drain("bp", 2, 5, 32'h100, 1, -1);
        if (rd_idx_q.size() - r0 == 4) begin
            check_eq("bp_idx0", 64'(rd_idx_q[r0]), 64'd0);
            check_eq("bp_idx1", 64'(rd_idx_q[r0 + 1]), 64'd2);
            check_eq("bp_idx2", 64'(rd_idx_q[r0 + 2]), 64'd1);
            check_eq("bp_idx3", 64'(rd_idx_q[r0 + 3]), 64'd3);
        end

        // Degenerate size: N=0.
        bc0 = busy_cnt;
        r0  = rd_idx_q.size();
        d0  = done_cnt;
        do_start(3, 0);
        wait_done(20, cyc, found);
        check_eq("degen_done_seen", 64'(found), 64'd1);
        check_eq("degen_done_cyc", 64'(cyc), 64'd1);
        repeat (4) @(negedge clk);
        #1;
        check_eq("degen_busy", 64'(busy_cnt - bc0), 64'd0);
        check_eq("degen_reads", 64'(rd_idx_q.size() - r0), 64'd0);
        check_eq("degen_done_pulses", 64'(done_cnt - d0), 64'd1);

        // Ignored restart: M=3 start mid-drain of M=2, N=4.
        fill_mem(2, 4, 32'h200);
        b0 = beat_data_q.size();
        r0 = rd_idx_q.size();
        d0 = done_cnt;
        do_start(2, 4);
        repeat (3) @(negedge clk);
        do_start(3, 4);
        wait_done(200, cyc, found);
        check_eq("restart_done_seen", 64'(found), 64'd1);
        repeat (6) @(negedge clk);
        #1;
        check_stream("restart", 2, 4, 32'h200, b0, r0);
        check_eq("restart_done_pulses", 64'(done_cnt - d0), 64'd1);

        // Mid-drain reset after 3 beats of M=4, N=4.
        fill_mem(4, 4, 32'h300);
        b0 = beat_data_q.size();
        d0 = done_cnt;
        do_start(4, 4);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (beat_data_q.size() - b0 >= 3) found = 1'b1;
        end
        check_eq("rst_three_beats", 64'(found), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_eq("rst_no_done", 64'(done_cnt - d0), 64'd0);
        run_drain("post_rst", 1, 1, 32'h400, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
